ntr_responder: RTL and testbench
================================

NTR_RESPONDER -- requirements
Module: ntr_responder

Interface
REQ-001 Parameter XFER_LEN, default 512, SHALL set the response length in bytes per command (range 4..4096).
REQ-002 Parameter CHIP_ID, default 32'h00000FC2, SHALL set the value returned by the chip-ID command.
REQ-003 clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 cmd_ready  in  1  level-high "8-byte command captured" from the command-capture stage; stays high until ntr_cs1 rises.
REQ-006 command  in  64  captured command; the first bus byte SHALL be command[63:56], the opcode.
REQ-007 ntr_clk  in  1  cartridge bus clock, asynchronous to clk.
REQ-008 ntr_cs1  in  1  cartridge select, active-low.
REQ-009 data_out  out  8  response byte presented to the bus.
REQ-010 data_oe  out  1  bus output enable for data_out.
REQ-011 rd_req  out  1  one-cycle byte-read request strobe to ROM backing store.
REQ-012 rd_addr  out  32  byte address, valid while rd_req is high.
REQ-013 rd_valid  in  1  one-cycle strobe: rd_data holds the requested byte.
REQ-014 rd_data  in  8  returned ROM byte.
REQ-015 underrun  out  1  sticky flag: host clocked a byte before it was fetched.

Function
REQ-016 ntr_clk SHALL pass a 2-flop synchronizer; a rising edge SHALL be detected on the third flop, 3 clk cycles after the pin edge.
REQ-017 The FSM SHALL have states IDLE, DECODE, FETCH, HOLD, DONE.
REQ-018 IDLE: when cmd_ready=1 and ntr_cs1=0, the block SHALL latch command, clear the byte counter and underrun, and enter DECODE next cycle; cmd_ready staying high SHALL not retrigger until IDLE is re-entered via ntr_cs1 high.
REQ-019 DECODE (1 cycle): opcode 8'h00 SHALL set base address 0 and go to FETCH; 8'hB7 SHALL set base = command[55:24] and go to FETCH; 8'h90 SHALL go to HOLD with byte CHIP_ID[7:0]; 8'h9F and all other opcodes SHALL go to HOLD with byte 8'hFF.
REQ-020 On FETCH entry rd_req SHALL pulse for exactly one cycle with rd_addr = base + count, modulo 2^32 (wraps 32'hFFFFFFFF to 0).
REQ-021 FETCH SHALL wait any number of cycles for rd_valid, then load rd_data into data_out and enter HOLD; rd_valid outside FETCH SHALL be ignored.
REQ-022 HOLD: on a detected ntr_clk rising edge the counter SHALL increment; if the old count was XFER_LEN-1 go to DONE, else FETCH (ROM opcodes) or stay in HOLD with the next constant byte.
REQ-023 Chip-ID byte at count n SHALL be CHIP_ID[8*(n mod 4)+7 : 8*(n mod 4)], repeating every 4 bytes.
REQ-024 A ntr_clk rising edge detected in FETCH SHALL set underrun and SHALL NOT advance the counter.
REQ-025 DONE SHALL drive data_out=8'hFF, data_oe=1, ignore ntr_clk, until ntr_cs1=1.
REQ-026 data_oe SHALL be 1 in FETCH, HOLD and DONE, 0 in IDLE and DECODE.
REQ-027 ntr_cs1=1 in any state SHALL force IDLE next cycle (data_oe=0, data_out=8'hFF), dropping any pending fetch; underrun SHALL hold its value.

Reset
REQ-028 rst_n=0 at a clk edge SHALL force IDLE, data_out=8'hFF, data_oe=0, rd_req=0, rd_addr=0, underrun=0, counter=0, synchronizer flops=0; reset SHALL override ntr_cs1 and cmd_ready.

Configuration
REQ-029 With macro NTR_RESPONDER_CHIP_ID_EN defined, opcode 8'h90 SHALL return CHIP_ID per REQ-023; undefined, 8'h90 SHALL be treated as unsupported (8'hFF bytes) and CHIP_ID SHALL be unused.

Verification
REQ-030 Cmd B7_00001000_000000 00, ROM[a]=a[7:0], rd_valid 2 cycles after rd_req -> 512 bytes 00..FF,00..FF, rd_addr 32'h1000..32'h11FF, underrun=0.
REQ-031 Cmd 90 with macro on -> bytes C2,0F,00,00 repeated 128 times; macro off -> 512 bytes FF, no rd_req.
REQ-032 Cmd B7_FFFFFFFE, XFER_LEN=4 -> rd_addr FFFFFFFE, FFFFFFFF, 00000000, 00000001; then DONE drives FF.
REQ-033 Cmd 00, rd_valid withheld across one ntr_clk rise -> underrun=1, byte 0 delivered on next rise, no byte skipped.
REQ-034 ntr_cs1 raised after byte 100 of cmd 00 -> IDLE, data_oe=0 next cycle, late rd_valid ignored; next command starts at count 0.
REQ-035 rst_n=0 for one cycle mid-HOLD -> all outputs at REQ-028 values next cycle; new command after release decodes normally.

Source files
------------

// File: rtl/ntr_responder.sv
// Cartridge-bus read responder: decodes a captured 8-byte command and streams
// XFER_LEN response bytes, fetching ROM bytes one at a time ahead of each ntr_clk rise.
// Optional chip-ID response to opcode 8'h90 is enabled by defining NTR_RESPONDER_CHIP_ID_EN.
//
// state   | meaning
// IDLE    | bus deselected or waiting for a captured command
// DECODE  | one cycle to classify the opcode and set the base address
// FETCH   | byte read outstanding to the ROM backing store
// HOLD    | current byte on the bus, waiting for the host to clock it
// DONE    | transfer length reached, bus held at 8'hFF until deselect
module ntr_responder #(
  parameter int          XFER_LEN = 512,
  parameter logic [31:0] CHIP_ID  = 32'h00000FC2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ready,
  input  logic [63:0] command,
  input  logic        ntr_clk,
  input  logic        ntr_cs1,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic        underrun
);

  localparam int            CW   = $clog2(XFER_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_FETCH,
    S_HOLD,
    S_DONE
  } state_t;

  state_t        state;
  logic [2:0]    ntr_sync;
  logic          ntr_rise;
  logic [7:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   base;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          rom_mode;
  logic [7:0]    const_nxt;
  logic [23:0]   unused_cmd;

  assign unused_cmd = command[23:0];
  assign ntr_rise   = ntr_sync[1] & ~ntr_sync[2];
  assign count_nxt  = count + CW'(1);

`ifdef NTR_RESPONDER_CHIP_ID_EN
  logic chip_mode;

  always_comb begin
    const_nxt = 8'hFF;
    if (chip_mode) const_nxt = CHIP_ID[{count_nxt[1:0], 3'b000} +: 8];
  end
`else
  logic [31:0] unused_chip_id;

  assign unused_chip_id = CHIP_ID;

  always_comb begin
    const_nxt = 8'hFF;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ntr_sync <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      base     <= '0;
      count    <= '0;
      rom_mode <= 1'b0;
`ifdef NTR_RESPONDER_CHIP_ID_EN
      chip_mode <= 1'b0;
`endif
      data_out <= 8'hFF;
      data_oe  <= 1'b0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      underrun <= 1'b0;
    end else begin
      ntr_sync <= {ntr_sync[1:0], ntr_clk};
      rd_req   <= 1'b0;
      // Deselect wins over everything; an outstanding fetch is simply abandoned.
      if (ntr_cs1) begin
        state    <= S_IDLE;
        data_oe  <= 1'b0;
        data_out <= 8'hFF;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_ready) begin
              op_q     <= command[63:56];
              addr_q   <= command[55:24];
              count    <= '0;
              underrun <= 1'b0;
              state    <= S_DECODE;
            end
          end
          S_DECODE: begin
            data_oe  <= 1'b1;
            rom_mode <= 1'b0;
`ifdef NTR_RESPONDER_CHIP_ID_EN
            chip_mode <= 1'b0;
`endif
            case (op_q)
              8'h00: begin
                base     <= '0;
                rom_mode <= 1'b1;
                rd_req   <= 1'b1;
                rd_addr  <= '0;
                state    <= S_FETCH;
              end
              8'hB7: begin
                base     <= addr_q;
                rom_mode <= 1'b1;
                rd_req   <= 1'b1;
                rd_addr  <= addr_q;
                state    <= S_FETCH;
              end
`ifdef NTR_RESPONDER_CHIP_ID_EN
              8'h90: begin
                chip_mode <= 1'b1;
                data_out  <= CHIP_ID[7:0];
                state     <= S_HOLD;
              end
`endif
              default: begin
                data_out <= 8'hFF;
                state    <= S_HOLD;
              end
            endcase
          end
          S_FETCH: begin
            if (ntr_rise) underrun <= 1'b1;
            if (rd_valid) begin
              data_out <= rd_data;
              state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (ntr_rise) begin
              count <= count_nxt;
              if (count == LAST) begin
                data_out <= 8'hFF;
                state    <= S_DONE;
              end else if (rom_mode) begin
                rd_req  <= 1'b1;
                rd_addr <= base + 32'(count_nxt);
                state   <= S_FETCH;
              end else begin
                data_out <= const_nxt;
              end
            end
          end
          S_DONE: begin
            data_out <= 8'hFF;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ntr_responder.sv
// Randomized scoreboard bench for ntr_responder: a host model issues commands and
// ntr_clk pulses, a ROM model answers reads, and monitors compare bytes and addresses.
module tb_ntr_responder;

  localparam int          XFER = 16;
  localparam logic [31:0] CID  = 32'h00000FC2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_ready = 1'b0;
  logic [63:0] command = '0;
  logic        ntr_clk = 1'b0;
  logic        ntr_cs1 = 1'b1;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        underrun;

  ntr_responder #(.XFER_LEN(XFER), .CHIP_ID(CID)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_ready(cmd_ready), .command(command),
    .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1), .data_out(data_out), .data_oe(data_oe),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_bytes[$];
  logic [31:0] exp_addr[$];
  int          rd_lat = 2;

  logic [7:0]  cur_op;
  logic [31:0] cur_base;
  int          cnt;
  logic        ur_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rom(input logic [31:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic bit is_rom(input logic [7:0] op);
    return (op == 8'h00) || (op == 8'hB7);
  endfunction

  // Byte n of the response as the host should see it.
  function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [31:0] base, input int n);
    logic [31:0] w;
    if (n >= XFER) return 8'hFF;
    if (is_rom(op)) return rom(base + 32'(n));
`ifdef NTR_RESPONDER_CHIP_ID_EN
    if (op == 8'h90) begin
      w = CID >> (8 * (n % 4));
      return w[7:0];
    end
`endif
    w = 32'hFF;
    return w[7:0];
  endfunction

  // ROM backing store: checks each request address, answers after rd_lat cycles.
  initial begin
    logic [31:0] a;
    int          lat;
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      if (rd_req === 1'b1) begin
        a   = rd_addr;
        lat = rd_lat;
        if (exp_addr.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_req_unexpected: got addr %h expected no request", a);
        end else begin
          check("rd_addr", a, exp_addr.pop_front());
        end
        repeat (lat) @(negedge clk);
        rd_valid = 1'b1;
        rd_data  = rom(a);
      end
    end
  end

  // Bus monitor: every host clock rise consumes one expected byte (-1 = don't care).
  initial begin
    int e;
    forever begin
      @(posedge ntr_clk);
      if (!ntr_cs1) begin
        if (exp_bytes.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL byte_unexpected: got %h expected none", data_out);
        end else begin
          e = exp_bytes.pop_front();
          check("data_oe_bus", 32'(data_oe), 32'd1);
          if (e >= 0) check("data_out", 32'(data_out), 32'(e));
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic start_cmd(input logic [7:0] op, input logic [31:0] addr);
    @(negedge clk);
    command  = {op, addr, 24'h0};
    cur_op   = op;
    cur_base = (op == 8'hB7) ? addr : 32'h0;
    cnt      = 0;
    ur_exp   = 1'b0;
    ntr_cs1  = 1'b0;
    cmd_ready = 1'b1;
    if (is_rom(op)) exp_addr.push_back(cur_base);
    repeat (10) @(posedge clk);
  endtask

  task automatic pulse();
    @(posedge clk);
    #3 ntr_clk = 1'b1;
    repeat (5) @(posedge clk);
    #3 ntr_clk = 1'b0;
    repeat (9) @(posedge clk);
  endtask

  task automatic push_rise();
    exp_bytes.push_back(int'(model_byte(cur_op, cur_base, cnt)));
    if (is_rom(cur_op) && (cnt + 1 < XFER)) exp_addr.push_back(cur_base + 32'(cnt + 1));
    cnt++;
  endtask

  task automatic rise_ok();
    push_rise();
    pulse();
  endtask

  task automatic rise_underrun();
    exp_bytes.push_back(-1);
    ur_exp = 1'b1;
    pulse();
  endtask

  task automatic end_cmd();
    repeat (5) @(posedge clk);
    @(negedge clk);
    ntr_cs1   = 1'b1;
    cmd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_oe", 32'(data_oe), 32'd0);
    check("idle_data", 32'(data_out), 32'hFF);
    check("underrun_end", 32'(underrun), 32'(ur_exp));
  endtask

  // Deselect while the fetch for the next byte is still outstanding.
  task automatic rise_then_abort();
    push_rise();
    @(posedge clk);
    #3 ntr_clk = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    ntr_clk   = 1'b0;
    ntr_cs1   = 1'b1;
    cmd_ready = 1'b0;
    @(posedge clk);
    #1;
    check("abort_oe", 32'(data_oe), 32'd0);
    check("abort_data", 32'(data_out), 32'hFF);
    repeat (20) @(posedge clk);
    #1;
    check("abort_late_valid", 32'(data_out), 32'hFF);
    check("abort_underrun", 32'(underrun), 32'(ur_exp));
  endtask

  task automatic check_reset_outputs();
    check("rst_data", 32'(data_out), 32'hFF);
    check("rst_oe", 32'(data_oe), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] addr;
    int          sel;
    int          nb;
    bit          abort;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Address wrap across 32'hFFFFFFFF, then DONE bytes.
    rd_lat = 2;
    start_cmd(8'hB7, 32'hFFFF_FFFE);
    repeat (XFER + 2) rise_ok();
    end_cmd();

    start_cmd(8'h00, 32'h1234_5678);
    repeat (XFER + 1) rise_ok();
    end_cmd();

    start_cmd(8'h90, 32'h0);
    repeat (XFER + 1) rise_ok();
    end_cmd();

    start_cmd(8'h9F, 32'h0);
    repeat (XFER) rise_ok();
    end_cmd();

    // Underrun: host clocks before the first byte arrives; then reset mid-HOLD.
    rd_lat = 30;
    start_cmd(8'h00, 32'h0);
    rise_underrun();
    repeat (15) @(posedge clk);
    rd_lat = 2;
    #1 check("underrun_set", 32'(underrun), 32'd1);
    repeat (3) rise_ok();
    @(negedge clk);
    rst_n     = 1'b0;
    ntr_cs1   = 1'b1;
    cmd_ready = 1'b0;
    @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    start_cmd(8'hB7, 32'h0000_1000);
    repeat (XFER) rise_ok();
    end_cmd();

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: op = 8'h00;
        1: op = 8'hB7;
        2: op = 8'h90;
        3: op = 8'h9F;
        default: op = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFFF - 32'($urandom_range(0, XFER));
      else addr = $urandom;
      abort  = ($urandom_range(0, 3) == 0);
      rd_lat = abort ? 4 : int'($urandom_range(0, 4));
      nb     = abort ? int'($urandom_range(1, XFER - 1)) : XFER + int'($urandom_range(0, 2));
      start_cmd(op, addr);
      if (abort) begin
        repeat (nb - 1) rise_ok();
        rise_then_abort();
        repeat (5) @(posedge clk);
      end else begin
        repeat (nb) rise_ok();
        end_cmd();
      end
    end

    repeat (30) @(posedge clk);
    check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
    check("byte_queue_drained", 32'(exp_bytes.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
